// File: rtl/lcd_byte_writer.sv
// Writes one byte to a 4-bit HD44780-style LCD as two nibbles, then waits out
// the controller's execution time (long wait for clear/home commands).
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned E_HIGH_CYCLES     = 12,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 2000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CNT_W = 32;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, HI_SETUP, HI_E, GAP, LO_SETUP, LO_E, WAIT, DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       byte_q;
  logic             rs_q;
  logic             accept_c;
  logic             is_clear_c;
  logic             cnt_zero_c;

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // oReady is only ever high in IDLE/DONE, so it alone qualifies an accept
  assign accept_c   = iValid && oReady;
  // Clear display (0x01) and return home (0x02/0x03) need the long wait
  assign is_clear_c = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
  assign cnt_zero_c = (cnt == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      byte_q              <= 8'h00;
      rs_q                <= 1'b0;
      oReady              <= 1'b0;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= 4'h0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE, DONE: begin
          oLCD_Enabled <= 1'b0;
          if (accept_c) begin
            byte_q              <= iData;
            rs_q                <= iRS;
            oLCD_Data           <= iData[7:4];
            oLCD_RegisterSelect <= iRS;
            oReady              <= 1'b0;
            cnt                 <= SETUP_LOAD;
            state               <= HI_SETUP;
          end else begin
            oReady <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        HI_SETUP: begin
          if (cnt_zero_c) begin
            oLCD_Enabled <= 1'b1;
            cnt          <= E_LOAD;
            state        <= HI_E;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI_E: begin
          if (cnt_zero_c) begin
            oLCD_Enabled <= 1'b0;
            cnt          <= GAP_LOAD;
            state        <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero_c) begin
            oLCD_Data <= byte_q[3:0];
            cnt       <= SETUP_LOAD;
            state     <= LO_SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LO_SETUP: begin
          if (cnt_zero_c) begin
            oLCD_Enabled <= 1'b1;
            cnt          <= E_LOAD;
            state        <= LO_E;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        LO_E: begin
          if (cnt_zero_c) begin
            oLCD_Enabled <= 1'b0;
            cnt          <= is_clear_c ? CLEAR_LOAD : CMD_LOAD;
            state        <= WAIT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt_zero_c) begin
            oDone  <= 1'b1;
            oReady <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          oLCD_Enabled <= 1'b0;
          oReady       <= 1'b0;
          cnt          <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_byte_writer.md
LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
 - SETUP_CYCLES, 2, cycles that RS/data are valid before E rises (>=1)
 - E_HIGH_CYCLES, 12, E pulse width in cycles (>=1; 240 ns at 50 MHz)
 - NIBBLE_GAP_CYCLES, 50, cycles with E low between the high and low nibble (>=1; 1 us)
 - CMD_WAIT_CYCLES, 2000, cycles after the low nibble for ordinary writes (>=1; 40 us)
 - CLEAR_WAIT_CYCLES, 82000, cycles after the low nibble for clear/home (>=1; 1.64 ms)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
 - Clock, input, 1, single clock for all logic
 - Reset, input, 1, asynchronous, active-high reset
 - iData, input, 8, byte to write
 - iRS, input, 1, register select: 0 = command, 1 = data
 - iValid, input, 1, request to write; iData/iRS are valid
 - oReady, output, 1, block is idle and can accept a byte
 - oDone, output, 1, one-cycle pulse when a byte write completes
 - oLCD_Enabled, output, 1, LCD E strobe
 - oLCD_RegisterSelect, output, 1, LCD RS
 - oLCD_ReadWrite, output, 1, LCD R/W, tied to 0 (write only)
 - oLCD_StrataFlashControl, output, 1, tied to 1 (StrataFlash disabled)
 - oLCD_Data, output, 4, LCD DB7..DB4
REQ-003 Clock and reset: one clock, Clock; Reset is asynchronous and active-high.

Function
REQ-004 oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReady and oDone SHALL each be driven from a register, so no output glitches.
REQ-005 FSM states SHALL be: IDLE, HI_SETUP, HI_E, GAP, LO_SETUP, LO_E, WAIT, DONE.
REQ-006 oReady SHALL be 1 only in IDLE and DONE; every other state SHALL hold oReady at 0.
REQ-007 Accept: at a rising edge where iValid=1 and oReady=1, the block SHALL latch iData and iRS and enter HI_SETUP.
REQ-008 iValid while oReady=0 SHALL be ignored; inputs need to be stable only at the accept edge.
REQ-009 HI_SETUP SHALL last SETUP_CYCLES cycles, with oLCD_Data = byte[7:4], RS = latched iRS and E = 0.
REQ-010 HI_E SHALL last E_HIGH_CYCLES cycles, with E = 1 and data/RS unchanged.
REQ-011 GAP SHALL last NIBBLE_GAP_CYCLES cycles, with E = 0 and data still byte[7:4].
REQ-012 LO_SETUP SHALL last SETUP_CYCLES cycles, with oLCD_Data = byte[3:0] and E = 0.
REQ-013 LO_E SHALL last E_HIGH_CYCLES cycles, with E = 1.
REQ-014 WAIT SHALL last CLEAR_WAIT_CYCLES cycles when latched RS = 0 and byte is 0x01, 0x02 or 0x03; otherwise it SHALL last CMD_WAIT_CYCLES cycles. E = 0 and data/RS are held throughout.
REQ-015 DONE SHALL last 1 cycle, with oDone = 1 and oReady = 1, then go to IDLE.
REQ-016 A new byte MAY be accepted in DONE (back-to-back); the FSM then goes directly to HI_SETUP.
REQ-017 Accept-to-oDone latency SHALL be 2*SETUP_CYCLES + 2*E_HIGH_CYCLES + NIBBLE_GAP_CYCLES + WAIT length + 1 cycles.
REQ-018 The single duration counter SHALL be 32 bits wide, SHALL reload on every state change, and SHALL never wrap during any state.
REQ-019 In IDLE, oLCD_Data and RS SHALL hold their last driven values and E SHALL be 0.

Reset
REQ-020 Reset SHALL asynchronously force:
 - state IDLE
 - oLCD_Enabled = 0, oLCD_RegisterSelect = 0, oLCD_Data = 4'h0
 - oDone = 0, counter = 0
 - latched byte = 8'h00, latched RS = 0
 - oReady = 1 on the first clock edge after Reset is released
REQ-021 Reset asserted mid-transfer, including during E high, SHALL drop E within the same cycle and abort the byte without emitting oDone.

Verification
Bench parameters: SETUP=2, E_HIGH=3, GAP=4, CMD_WAIT=5, CLEAR_WAIT=20.
REQ-022 Data write: iData = 0x41, iRS = 1, accept at cycle 0 -> E high in cycles 3-5 with data 4 and cycles 12-14 with data 1; RS = 1 throughout; oDone and oReady = 1 at cycle 20.
REQ-023 Clear: iData = 0x01, iRS = 0 -> nibbles 0 then 1, RS = 0; oDone at cycle 35. Repeat with iRS = 1 -> oDone at cycle 20.
REQ-024 Back-to-back: iValid held high with 0x28 then 0x0C -> second accept in the DONE cycle of the first; exactly 4 E pulses in total; no idle gap between the two transfers.
REQ-025 Busy input: toggle iValid and iData during cycles 1-19 of a transfer -> data nibbles unchanged and no extra transfer.
REQ-026 Reset at cycle 4 (during E high) -> E = 0 immediately; no oDone; oReady = 1 after release; a following 0x41 write behaves exactly as in REQ-022.
